// File: rtl/hist2d_readout.sv
// Receive side of the hist2d bin-output interface: stores reported bins in a local RAM
// and streams the whole 2D histogram as a framed byte stream (A5, eff_i, eff_q, bins, 5A).
module hist2d_readout #(
  parameter int MAX_I_BINS = 16,
  parameter int MAX_Q_BINS = 16,
  parameter int ADDR_W     = 8
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic [7:0]  i_bin_num,
  input  logic [7:0]  q_bin_num,
  input  logic        bin_found,
  input  logic [7:0]  i_bin_coord,
  input  logic [7:0]  q_bin_coord,
  input  logic [15:0] bin_val,
  input  logic        dump_start,
  input  logic        clear_req,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        drop_flag
);

  localparam int DEPTH = MAX_I_BINS * MAX_Q_BINS;

  typedef enum logic [3:0] {
    S_CLEAR, S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_FETCH, S_SEND_HI, S_SEND_LO, S_TRAIL
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [7:0]        i_cnt, q_cnt;
  logic [7:0]        eff_i, eff_q;
  logic [7:0]        rd_lo;
  logic [15:0]       mem [0:DEPTH-1];

  logic [7:0]        live_eff_i, live_eff_q;
  logic              beat_ok, tx_fire, last_i, last_q;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;

  assign live_eff_i = (i_bin_num > 8'(MAX_I_BINS)) ? 8'(MAX_I_BINS) : i_bin_num;
  assign live_eff_q = (q_bin_num > 8'(MAX_Q_BINS)) ? 8'(MAX_Q_BINS) : q_bin_num;
  assign beat_ok    = (i_bin_coord < live_eff_i) && (q_bin_coord < live_eff_q);
  assign wr_addr    = ADDR_W'(int'(q_bin_coord) * MAX_I_BINS + int'(i_bin_coord));
  assign rd_addr    = ADDR_W'(int'(q_cnt) * MAX_I_BINS + int'(i_cnt));
  assign tx_fire    = tx_valid && tx_ready;
  assign last_i     = (i_cnt == eff_i - 8'd1);
  assign last_q     = (q_cnt == eff_q - 8'd1);

  // Single write port shared by the clear sweep and live bin updates.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = bin_val;
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (state == S_IDLE && bin_found && beat_ok) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the bin RAM has no reset; the CLEAR sweep after rst zeroes it, which keeps it mappable to block RAM.
  always_ff @(posedge clk100) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk100) begin
    if (rst) begin
      state     <= S_CLEAR;
      clr_addr  <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b1;
      drop_flag <= 1'b0;
      i_cnt     <= '0;
      q_cnt     <= '0;
      eff_i     <= '0;
      eff_q     <= '0;
      rd_lo     <= '0;
    end else begin
      if (bin_found && (state != S_IDLE || !beat_ok)) drop_flag <= 1'b1;
      case (state)
        S_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            clr_addr  <= '0;
            drop_flag <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (clear_req) begin
            busy  <= 1'b1;
            state <= S_CLEAR;
          end else if (dump_start) begin
            eff_i    <= live_eff_i;
            eff_q    <= live_eff_q;
            i_cnt    <= '0;
            q_cnt    <= '0;
            tx_valid <= 1'b1;
            tx_data  <= 8'hA5;
            busy     <= 1'b1;
            state    <= S_HDR0;
          end
        end
        S_HDR0: if (tx_fire) begin
          tx_data <= eff_i;
          state   <= S_HDR1;
        end
        S_HDR1: if (tx_fire) begin
          tx_data <= eff_q;
          state   <= S_HDR2;
        end
        S_HDR2: if (tx_fire) begin
          if (eff_i == 8'd0 || eff_q == 8'd0) begin
            tx_data <= 8'h5A;
            state   <= S_TRAIL;
          end else begin
            tx_valid <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Synchronous read lands the high byte directly in the output register.
          tx_data  <= mem[rd_addr][15:8];
          rd_lo    <= mem[rd_addr][7:0];
          tx_valid <= 1'b1;
          state    <= S_SEND_HI;
        end
        S_SEND_HI: if (tx_fire) begin
          tx_data <= rd_lo;
          state   <= S_SEND_LO;
        end
        S_SEND_LO: if (tx_fire) begin
          if (last_i) begin
            i_cnt <= '0;
            q_cnt <= q_cnt + 8'd1;
          end else begin
            i_cnt <= i_cnt + 8'd1;
          end
          if (last_i && last_q) begin
            tx_data <= 8'h5A;
            state   <= S_TRAIL;
          end else begin
            tx_valid <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_TRAIL: if (tx_fire) begin
          tx_valid <= 1'b0;
          tx_data  <= '0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule
